// File: rtl/division.sv
// ---------------------------------------------------------------------------
// division : sequential radix-2 restoring divider (DIV/DIVU/REM/REMU).
// One quotient bit per clock over operand magnitudes, then a sign fix-up.
// Divide-by-zero and signed overflow bypass the iteration loop.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module division #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [0:WIDTH-1] D1,
    input  logic [0:WIDTH-1] D2,
    output logic             busy,
    output logic             done,
    output logic [0:WIDTH-1] Q,
    output logic [0:WIDTH-1] R
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Ports are MSB-first; these views keep the arithmetic in ordinary order.
    logic [WIDTH-1:0] d1_v;
    logic [WIDTH-1:0] d2_v;
    assign d1_v = D1;
    assign d2_v = D2;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] rem_q;     // partial remainder
    logic [WIDTH-1:0] quo_q;     // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] div_q;     // divisor magnitude
    logic             qneg_q;
    logic             rneg_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;

    logic [WIDTH-1:0] abs1_d;
    logic [WIDTH-1:0] abs2_d;
    logic [WIDTH:0]   shift_d;
    logic [WIDTH:0]   trial_d;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic             ovf_d;

    // Operand magnitudes, special-case detect and one restoring step.
    always_comb begin
        abs1_d  = (is_signed && d1_v[WIDTH-1]) ? (~d1_v + 1'b1) : d1_v;
        abs2_d  = (is_signed && d2_v[WIDTH-1]) ? (~d2_v + 1'b1) : d2_v;
        ovf_d   = is_signed && (d1_v == {1'b1, {(WIDTH-1){1'b0}}}) && (d2_v == '1);
        shift_d = {rem_q, quo_q[WIDTH-1]};
        trial_d = shift_d - {1'b0, div_q};
        if (!trial_d[WIDTH]) begin
            rem_d = trial_d[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = shift_d[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q  <= 1'b1;
                        count_q <= '0;
                        if (d2_v == '0) begin
                            // Results preloaded; FIX passes them through unsigned.
                            quo_q   <= '1;
                            rem_q   <= d1_v;
                            qneg_q  <= 1'b0;
                            rneg_q  <= 1'b0;
                            state_q <= S_FIX;
                        end else if (ovf_d) begin
                            quo_q   <= {1'b1, {(WIDTH-1){1'b0}}};
                            rem_q   <= '0;
                            qneg_q  <= 1'b0;
                            rneg_q  <= 1'b0;
                            state_q <= S_FIX;
                        end else begin
                            quo_q   <= abs1_d;
                            div_q   <= abs2_d;
                            rem_q   <= '0;
                            qneg_q  <= is_signed && (d1_v[WIDTH-1] ^ d2_v[WIDTH-1]);
                            rneg_q  <= is_signed && d1_v[WIDTH-1];
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem_q   <= rem_d;
                    quo_q   <= quo_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == CW'(WIDTH - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    // Negating a zero remainder leaves it zero.
                    q_q     <= qneg_q ? (~quo_q + 1'b1) : quo_q;
                    r_q     <= rneg_q ? (~rem_q + 1'b1) : rem_q;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Q    = q_q;
    assign R    = r_q;

endmodule

`default_nettype wire
